// File: rtl/nios2_debug_ocimem_arbiter_pkg.sv
// Shared types and jdo field positions for the OCI memory arbiter.
package nios2_debug_ocimem_arbiter_pkg;

  localparam int unsigned DATA_W       = 32;
  localparam int unsigned BE_W         = 4;
  localparam int unsigned JDO_W        = 38;
  localparam int unsigned JDO_ADDR_LSB = 10;
  localparam int unsigned JDO_ADDR_MSB = 17;
  localparam int unsigned JDO_DATA_LSB = 3;
  localparam int unsigned JDO_DATA_MSB = 34;
  localparam int unsigned JDO_RDQ_BIT  = 34;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_JRD  = 2'd1,
    ST_CRD  = 2'd2
  } state_e;

  typedef enum logic {
    GNT_CPU  = 1'b0,
    GNT_JTAG = 1'b1
  } side_e;

  typedef enum logic {
    JOP_READ  = 1'b0,
    JOP_WRITE = 1'b1
  } jop_e;

  typedef struct packed {
    jop_e              op;
    logic [DATA_W-1:0] data;
  } jtag_cmd_t;

  function automatic logic [DATA_W-1:0] jdo_data(input logic [JDO_W-1:0] jdo);
    return jdo[JDO_DATA_MSB:JDO_DATA_LSB];
  endfunction

endpackage

// File: rtl/nios2_debug_ocimem_arbiter_if.sv
// CPU debug-slave bus (Avalon-style, waitrequest handshake).
interface nios2_debug_ocimem_arbiter_if #(
  parameter int unsigned ADDR_W = 8
) ();
  import nios2_debug_ocimem_arbiter_pkg::*;

  logic [ADDR_W-1:0] cpu_address;
  logic              cpu_read;
  logic              cpu_write;
  logic [DATA_W-1:0] cpu_writedata;
  logic [BE_W-1:0]   cpu_byteenable;
  logic              cpu_waitrequest;
  logic [DATA_W-1:0] cpu_readdata;

  modport master (
    output cpu_address, cpu_read, cpu_write, cpu_writedata, cpu_byteenable,
    input  cpu_waitrequest, cpu_readdata
  );

  modport slave (
    input  cpu_address, cpu_read, cpu_write, cpu_writedata, cpu_byteenable,
    output cpu_waitrequest, cpu_readdata
  );
endinterface

// File: rtl/nios2_debug_jtag_cmd_slot.sv
// One-deep JTAG command slot with auto-incrementing address pointer and
// sticky overrun flag.
module nios2_debug_jtag_cmd_slot
  import nios2_debug_ocimem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [JDO_W-1:0]  jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic              grant,
  output logic              pending,
  output jtag_cmd_t         cmd,
  output logic [ADDR_W-1:0] ptr,
  output logic              overrun
);

  logic              pending_q, pending_d;
  jtag_cmd_t         cmd_q, cmd_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              overrun_q, overrun_d;
  logic              rd_req, wr_req, queue_req, drop;
  logic              unused_jdo;

  assign unused_jdo = ^jdo;

  always_comb begin
    rd_req    = (take_action_ocimem_a & jdo[JDO_RDQ_BIT]) | take_no_action_ocimem_a;
    wr_req    = take_action_ocimem_b;
    queue_req = rd_req | wr_req;
    drop      = queue_req & pending_q;

    pending_d = pending_q & ~grant;
    cmd_d     = cmd_q;
    ptr_d     = ptr_q;
    overrun_d = overrun_q | drop;

    if (queue_req && !pending_q) begin
      pending_d  = 1'b1;
      cmd_d.op   = wr_req ? JOP_WRITE : JOP_READ;
      cmd_d.data = jdo_data(jdo);
    end
    if (grant) begin
      ptr_d = ptr_q + ADDR_W'(1);
    end
    // A pointer load starts a new sequence: it overrides the increment and
    // re-arms the overrun flag (unless this very strobe is itself dropped).
    if (take_action_ocimem_a) begin
      ptr_d     = jdo[JDO_ADDR_LSB +: ADDR_W];
      overrun_d = drop;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= 1'b0;
      cmd_q     <= '0;
      ptr_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      cmd_q     <= cmd_d;
      ptr_q     <= ptr_d;
      overrun_q <= overrun_d;
    end
  end

  assign pending = pending_q;
  assign cmd     = cmd_q;
  assign ptr     = ptr_q;
  assign overrun = overrun_q;

endmodule

// File: rtl/nios2_debug_ocimem_arbiter.sv
// Shares the single-port OCI debug RAM between the JTAG command slot and the
// CPU debug slave; one RAM access per IDLE cycle, 1-cycle read latency.
module nios2_debug_ocimem_arbiter
  import nios2_debug_ocimem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W          = 8,
  parameter bit          FIXED_JTAG_PRIO = 1'b0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [JDO_W-1:0]             jdo,
  input  logic                         take_action_ocimem_a,
  input  logic                         take_action_ocimem_b,
  input  logic                         take_no_action_ocimem_a,
  nios2_debug_ocimem_arbiter_if.slave  cpu,
  output logic [ADDR_W-1:0]            ram_address,
  output logic                         ram_wren,
  output logic [DATA_W-1:0]            ram_wdata,
  output logic [BE_W-1:0]              ram_byteen,
  input  logic [DATA_W-1:0]            ram_rdata,
  output logic [DATA_W-1:0]            MonDReg,
  output logic                         mon_valid,
  output logic                         jtag_overrun
);

  state_e            state_q, state_d;
  side_e             last_grant_q, last_grant_d;
  logic [DATA_W-1:0] mon_dreg_q, mon_dreg_d;
  logic              mon_valid_q, mon_valid_d;

  logic              jtag_pending;
  jtag_cmd_t         jtag_cmd;
  logic [ADDR_W-1:0] jtag_ptr;
  logic              cpu_req, in_idle, crd_live, contested, pick_jtag;
  logic              jtag_gnt, cpu_gnt;

  nios2_debug_jtag_cmd_slot #(.ADDR_W(ADDR_W)) u_slot (
    .clk                     (clk),
    .reset                   (reset),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .grant                   (jtag_gnt),
    .pending                 (jtag_pending),
    .cmd                     (jtag_cmd),
    .ptr                     (jtag_ptr),
    .overrun                 (jtag_overrun)
  );

  // Arbitration; nothing is granted while reset is held.
  assign cpu_req   = cpu.cpu_read | cpu.cpu_write;
  assign in_idle   = (state_q == ST_IDLE) & ~reset;
  assign crd_live  = (state_q == ST_CRD) & ~reset;
  assign contested = jtag_pending & cpu_req;
  assign pick_jtag = jtag_pending &
                     (~cpu_req | FIXED_JTAG_PRIO | (last_grant_q == GNT_CPU));
  assign jtag_gnt  = in_idle & pick_jtag;
  assign cpu_gnt   = in_idle & cpu_req & ~pick_jtag;

  assign ram_address = jtag_gnt ? jtag_ptr : cpu.cpu_address;
  assign ram_wren    = (jtag_gnt & (jtag_cmd.op == JOP_WRITE)) | (cpu_gnt & cpu.cpu_write);
  assign ram_wdata   = jtag_gnt ? jtag_cmd.data : cpu.cpu_writedata;
  assign ram_byteen  = jtag_gnt ? {BE_W{1'b1}} : cpu.cpu_byteenable;

  assign cpu.cpu_waitrequest = cpu_req & ~((cpu_gnt & cpu.cpu_write) | crd_live);
  assign cpu.cpu_readdata    = crd_live ? ram_rdata : '0;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    mon_dreg_d   = mon_dreg_q;
    mon_valid_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (jtag_gnt && (jtag_cmd.op == JOP_READ)) begin
          state_d = ST_JRD;
        end else if (cpu_gnt && !cpu.cpu_write) begin
          state_d = ST_CRD;
        end
      end
      ST_JRD: begin
        mon_dreg_d  = ram_rdata;
        mon_valid_d = 1'b1;
        state_d     = ST_IDLE;
      end
      ST_CRD:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Alternation only remembers who won a real tie.
    if (in_idle && contested) begin
      last_grant_d = jtag_gnt ? GNT_JTAG : GNT_CPU;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= GNT_CPU;
      mon_dreg_q   <= '0;
      mon_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      mon_dreg_q   <= mon_dreg_d;
      mon_valid_q  <= mon_valid_d;
    end
  end

  assign MonDReg   = mon_dreg_q;
  assign mon_valid = mon_valid_q;

endmodule
